// File: rtl/mapa_arbiter.sv
// Single-port map RAM arbiter: renderer reads take priority, game requests queue in a FIFO
// and drain in free cycles, with a starvation counter forcing a game slot during long bursts.
module mapa_arbiter #(
    parameter int MAP_W        = 40,
    parameter int MAP_H        = 30,
    parameter int COR_BITS     = 6,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 800,
    parameter int ADDR_W       = $clog2(MAP_W * MAP_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pixel_read,
    input  logic [9:0]          mapa_x,
    input  logic [9:0]          mapa_y,
    output logic [COR_BITS-1:0] mapa_cor,
    output logic                mapa_valid,
    output logic                mapa_miss,
    input  logic                g_req,
    input  logic                g_we,
    input  logic [9:0]          g_x,
    input  logic [9:0]          g_y,
    input  logic [COR_BITS-1:0] g_wdata,
    output logic                g_ready,
    output logic                g_rvalid,
    output logic [COR_BITS-1:0] g_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [COR_BITS-1:0] ram_wdata,
    input  logic [COR_BITS-1:0] ram_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef struct packed {
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [COR_BITS-1:0] wdata;
        logic                oob;
    } entry_t;

    function automatic logic [ADDR_W-1:0] map_addr(input logic [9:0] x, input logic [9:0] y);
        logic [20:0] lin;
        lin = 21'(y) * 21'(MAP_W) + 21'(x);
        return lin[ADDR_W-1:0];
    endfunction

    function automatic logic out_of_range(input logic [9:0] x, input logic [9:0] y);
        return (int'(x) >= MAP_W) || (int'(y) >= MAP_H);
    endfunction

    entry_t              fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [COR_BITS-1:0] last_wdata_q;
    logic                r_vld_q, r_oob_q, miss_q;
    logic                g_vld_q, g_oob_q;
    logic [COR_BITS-1:0] cor_q, grd_q;

    logic                fifo_empty, fifo_full, push;
    logic                force_slot, rend_slot, game_slot;
    logic                r_oob;
    logic [ADDR_W-1:0]   r_addr;
    entry_t              head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];

    assign g_ready    = !reset && !fifo_full;
    assign push       = g_req && g_ready;

    assign r_oob      = out_of_range(mapa_x, mapa_y);
    assign r_addr     = map_addr(mapa_x, mapa_y);

    // Slot priority: forced game slot, then renderer, then game in free cycles.
    assign force_slot = !reset && !fifo_empty && (starve_q == CNT_MAX);
    assign rend_slot  = !reset && pixel_read && !force_slot;
    assign game_slot  = !reset && !fifo_empty && (force_slot || !pixel_read);

    always_comb begin
        ram_addr  = last_addr_q;
        ram_we    = 1'b0;
        ram_wdata = last_wdata_q;
        if (reset) begin
            ram_addr  = '0;
            ram_wdata = '0;
        end else if (rend_slot) begin
            if (!r_oob) ram_addr = r_addr;
        end else if (game_slot && !head.oob) begin
            ram_addr = head.addr;
            ram_we   = head.we;
            if (head.we) ram_wdata = head.wdata;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        starve_d = starve_q;
        if (push)      wr_ptr_d = wr_ptr_q + 1'b1;
        if (game_slot) rd_ptr_d = rd_ptr_q + 1'b1;
        if (fifo_empty || game_slot) starve_d = '0;
        else if (starve_q != CNT_MAX) starve_d = starve_q + 1'b1;
    end

    // Queue storage carries no reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{we:    g_we,
                                             addr:  map_addr(g_x, g_y),
                                             wdata: g_wdata,
                                             oob:   out_of_range(g_x, g_y)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            starve_q     <= '0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
            r_vld_q      <= 1'b0;
            r_oob_q      <= 1'b0;
            miss_q       <= 1'b0;
            g_vld_q      <= 1'b0;
            g_oob_q      <= 1'b0;
            cor_q        <= '0;
            grd_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            starve_q     <= starve_d;
            last_addr_q  <= ram_addr;
            last_wdata_q <= ram_wdata;
            r_vld_q      <= rend_slot;
            r_oob_q      <= r_oob;
            miss_q       <= pixel_read && force_slot;
            g_vld_q      <= game_slot && !head.we;
            g_oob_q      <= head.oob;
            cor_q        <= mapa_cor;
            grd_q        <= g_rdata;
        end
    end

    // Read results use the RAM's registered data in the cycle after issue; otherwise hold.
    assign mapa_valid = !reset && r_vld_q;
    assign mapa_miss  = !reset && miss_q;
    assign mapa_cor   = reset   ? '0 :
                        r_vld_q ? (r_oob_q ? '0 : ram_rdata) : cor_q;
    assign g_rvalid   = !reset && g_vld_q;
    assign g_rdata    = reset   ? '0 :
                        g_vld_q ? (g_oob_q ? '0 : ram_rdata) : grd_q;

endmodule

// File: tb/tb_mapa_arbiter.sv
// Bench for mapa_arbiter: a RAM model, a queue-based reference of the arbitration rules,
// directed scenarios and a randomized phase.
module tb_mapa_arbiter;

    localparam int MAP_W = 40;
    localparam int MAP_H = 30;
    localparam int CB    = 6;
    localparam int DEPTH = 4;
    localparam int LIMIT = 800;
    localparam int AW    = 11;
    localparam int WORDS = MAP_W * MAP_H;

    logic          clk = 1'b0;
    logic          reset;
    logic          pixel_read;
    logic [9:0]    mapa_x, mapa_y;
    logic [CB-1:0] mapa_cor;
    logic          mapa_valid, mapa_miss;
    logic          g_req, g_we;
    logic [9:0]    g_x, g_y;
    logic [CB-1:0] g_wdata;
    logic          g_ready, g_rvalid;
    logic [CB-1:0] g_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [CB-1:0] ram_wdata;
    logic [CB-1:0] ram_rdata;

    always #5 clk = ~clk;

    mapa_arbiter #(.MAP_W(MAP_W), .MAP_H(MAP_H), .COR_BITS(CB), .FIFO_DEPTH(DEPTH),
                   .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .pixel_read(pixel_read), .mapa_x(mapa_x), .mapa_y(mapa_y),
        .mapa_cor(mapa_cor), .mapa_valid(mapa_valid), .mapa_miss(mapa_miss),
        .g_req(g_req), .g_we(g_we), .g_x(g_x), .g_y(g_y), .g_wdata(g_wdata),
        .g_ready(g_ready), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

    // Map RAM: registered read, preloaded on the first clock with word i = i[5:0] ^ 6'h39.
    logic [CB-1:0] mem [WORDS];
    logic          mem_init_q = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_q) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 6'(i) ^ 6'h39;
            mem_init_q <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending game ops as a queue, expected map contents as an array.
    typedef struct {
        bit       we;
        int       addr;
        bit [5:0] wd;
        bit       oob;
    } req_t;

    req_t     mq[$];
    bit [5:0] shadow [WORDS];
    int       m_starve   = 0;
    bit       e_mv       = 0;
    bit       e_miss     = 0;
    bit       e_grv      = 0;
    bit [5:0] e_cor      = 0;
    bit [5:0] e_grd      = 0;
    int       e_last     = 0;

    task automatic model_cycle();
        bit   has, forced, rend, game, roob, ew, accept;
        int   raddr, ea;
        req_t h;
        if (reset) begin
            check_eq("rst_mapa_valid", int'(mapa_valid), 0);
            check_eq("rst_mapa_miss",  int'(mapa_miss), 0);
            check_eq("rst_mapa_cor",   int'(mapa_cor), 0);
            check_eq("rst_g_rvalid",   int'(g_rvalid), 0);
            check_eq("rst_g_rdata",    int'(g_rdata), 0);
            check_eq("rst_ram_we",     int'(ram_we), 0);
            check_eq("rst_ram_addr",   int'(ram_addr), 0);
            check_eq("rst_ram_wdata",  int'(ram_wdata), 0);
            check_eq("rst_g_ready",    int'(g_ready), 0);
            mq.delete();
            m_starve = 0;
            e_mv = 0; e_miss = 0; e_grv = 0; e_cor = 0; e_grd = 0; e_last = 0;
            return;
        end
        check_eq("g_ready",    int'(g_ready), (mq.size() < DEPTH) ? 1 : 0);
        check_eq("mapa_valid", int'(mapa_valid), int'(e_mv));
        check_eq("mapa_miss",  int'(mapa_miss), int'(e_miss));
        check_eq("mapa_cor",   int'(mapa_cor), int'(e_cor));
        check_eq("g_rvalid",   int'(g_rvalid), int'(e_grv));
        check_eq("g_rdata",    int'(g_rdata), int'(e_grd));

        has    = (mq.size() > 0);
        forced = has && (m_starve == LIMIT);
        rend   = pixel_read && !forced;
        game   = has && (forced || !pixel_read);
        raddr  = int'(mapa_y) * MAP_W + int'(mapa_x);
        roob   = (int'(mapa_x) >= MAP_W) || (int'(mapa_y) >= MAP_H);
        h      = '{we: 0, addr: 0, wd: 0, oob: 0};
        if (has) h = mq[0];

        ea = e_last;
        ew = 0;
        if (rend) begin
            if (!roob) ea = raddr;
        end else if (game && !h.oob) begin
            ea = h.addr;
            ew = h.we;
        end
        check_eq("ram_addr", int'(ram_addr), ea);
        check_eq("ram_we",   int'(ram_we), int'(ew));
        if (ew) check_eq("ram_wdata", int'(ram_wdata), int'(h.wd));
        e_last = ea;

        e_mv   = rend;
        e_miss = pixel_read && forced;
        if (rend) e_cor = roob ? 6'd0 : shadow[raddr];
        e_grv  = game && !h.we;
        if (e_grv) e_grd = h.oob ? 6'd0 : shadow[h.addr];
        if (game && h.we && !h.oob) shadow[h.addr] = h.wd;

        if (!has || game) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;

        accept = g_req && (mq.size() < DEPTH);
        if (game) void'(mq.pop_front());
        if (accept)
            mq.push_back('{we: g_we, addr: int'(g_y) * MAP_W + int'(g_x), wd: g_wdata,
                           oob: (int'(g_x) >= MAP_W) || (int'(g_y) >= MAP_H)});
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen_at, n_miss, n_grv, wseen;
        for (int i = 0; i < WORDS; i++) shadow[i] = 6'(i) ^ 6'h39;
        reset = 1; pixel_read = 0; mapa_x = 0; mapa_y = 0;
        g_req = 0; g_we = 0; g_x = 0; g_y = 0; g_wdata = 0;
        @(posedge clk); #1;
        repeat (3) step();
        reset = 0;

        // Renderer read of (3,2) -> word 83
        pixel_read = 1; mapa_x = 3; mapa_y = 2;
        #1 check_eq("tp1_addr", int'(ram_addr), 83);
        step();
        pixel_read = 0;
        check_eq("tp1_valid", int'(mapa_valid), 1);
        check_eq("tp1_cor", int'(mapa_cor), 'h2A);

        // Game write (5,1)=0x15 then read back
        g_req = 1; g_we = 1; g_x = 5; g_y = 1; g_wdata = 6'h15;
        step();
        g_we = 0;
        #1 check_eq("tp2_we", int'(ram_we), 1);
        check_eq("tp2_waddr", int'(ram_addr), 45);
        step();
        g_req = 0;
        #1 check_eq("tp2_rd_we", int'(ram_we), 0);
        check_eq("tp2_raddr", int'(ram_addr), 45);
        step();
        check_eq("tp2_rvalid", int'(g_rvalid), 1);
        check_eq("tp2_rdata", int'(g_rdata), 'h15);
        step();

        // Starvation: renderer holds the port, five requests offered, four accepted
        pixel_read = 1; mapa_x = 1; mapa_y = 1;
        seen_at = -1; n_miss = 0;
        for (int s = 0; s < 3260; s++) begin
            g_req = (s < 5); g_we = 1; g_x = 10'(s); g_y = 3; g_wdata = 6'(s + 1);
            if (s >= 5) begin
                mapa_x = 10'($urandom_range(0, MAP_W - 1));
                mapa_y = 10'($urandom_range(0, MAP_H - 1));
            end
            step();
            if (s == 3) check_eq("starve_full", int'(g_ready), 0);
            if (mapa_miss) begin
                n_miss++;
                if (seen_at < 0) seen_at = s;
            end
        end
        check_eq("starve_first_miss", seen_at, LIMIT + 1);
        check_eq("starve_miss_count", n_miss, 4);
        check_eq("starve_drained", int'(g_ready), 1);

        // Out-of-range renderer read and dropped game write
        pixel_read = 1; mapa_x = 40; mapa_y = 0; g_req = 0;
        #1 check_eq("oob_r_we", int'(ram_we), 0);
        step();
        check_eq("oob_r_valid", int'(mapa_valid), 1);
        check_eq("oob_r_cor", int'(mapa_cor), 0);
        pixel_read = 0;
        g_req = 1; g_we = 1; g_x = 0; g_y = 30; g_wdata = 6'h3F;
        step();
        g_req = 0;
        #1 check_eq("oob_w_we", int'(ram_we), 0);
        step();
        g_req = 1; g_we = 0; g_x = 0; g_y = 29;
        step();
        g_req = 0;
        step();
        check_eq("oob_w_untouched", int'(g_rdata), int'(6'(1160) ^ 6'h39));
        step();

        // Reset in the cycle a queued game read would issue
        pixel_read = 1; g_req = 1; g_we = 0; g_x = 2; g_y = 2;
        step();
        g_req = 0; pixel_read = 0; reset = 1;
        step();
        step();
        reset = 0;
        #1 check_eq("rst_mid_ready", int'(g_ready), 1);
        n_grv = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (g_rvalid) n_grv++;
        end
        check_eq("rst_mid_no_rvalid", n_grv, 0);

        // pixel_read toggles every cycle while four writes drain in the gaps
        wseen = 0;
        for (int c = 0; c < 12; c++) begin
            pixel_read = (c % 2 == 0); mapa_x = 10'(c); mapa_y = 7;
            g_req = (c < 4); g_we = 1; g_x = 10'(10 + c); g_y = 5; g_wdata = 6'(32 + c);
            #1;
            if (ram_we) begin
                check_eq("ilv_slot", int'(pixel_read), 0);
                check_eq("ilv_order", int'(ram_addr), 5 * MAP_W + 10 + wseen);
                wseen++;
            end
            step();
        end
        check_eq("ilv_count", wseen, 4);

        // Randomized traffic, including out-of-range coordinates
        for (int c = 0; c < 3000; c++) begin
            pixel_read = ($urandom_range(0, 9) < 6);
            mapa_x     = 10'($urandom_range(0, 44));
            mapa_y     = 10'($urandom_range(0, 33));
            g_req      = ($urandom_range(0, 9) < 4);
            g_we       = $urandom_range(0, 1) == 1;
            g_x        = 10'($urandom_range(0, 44));
            g_y        = 10'($urandom_range(0, 33));
            g_wdata    = 6'($urandom);
            reset      = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 0; pixel_read = 0; g_req = 0;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mapa_arbiter.md
Name: mapa_arbiter

Overview:
- Shares the single-port map RAM between the renderer (pixel-rate reads) and the game logic (tile reads/writes).
- Renderer has priority while pixel_read is high. Game requests are queued in a small FIFO and drained in free cycles.
- A starvation counter guarantees the game forward progress during long active-video stretches.
- Sits between renderer, game FSM and the map RAM instance.

Parameters:
- MAP_W, 40, map width in blocks (640/16)
- MAP_H, 30, map height in blocks (480/16)
- COR_BITS, 6, colour/tile word width
- FIFO_DEPTH, 4, game request queue depth (power of 2)
- STARVE_LIMIT, 800, consecutive denied cycles before a forced game slot
- ADDR_W, $clog2(MAP_W*MAP_H), RAM address width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_read  in  1  renderer requests a read this cycle
- mapa_x  in  10  renderer block column
- mapa_y  in  10  renderer block row
- mapa_cor  out  COR_BITS  read data to renderer
- mapa_valid  out  1  mapa_cor valid (1 cycle after accepted read)
- mapa_miss  out  1  pulse: renderer read displaced by forced game slot
- g_req  in  1  game request strobe
- g_we  in  1  1=write, 0=read
- g_x  in  10  game block column
- g_y  in  10  game block row
- g_wdata  in  COR_BITS  write data
- g_ready  out  1  FIFO not full; request accepted when g_req&&g_ready
- g_rvalid  out  1  read-data pulse for game read
- g_rdata  out  COR_BITS  game read data
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  COR_BITS  RAM write data
- ram_rdata  in  COR_BITS  RAM read data, registered, 1-cycle latency

Behaviour:
- Address = y*MAP_W + x. The address is out of range if x>=MAP_W or y>=MAP_H.
- One RAM operation per cycle. Slot selection, in priority order:
  - (a) Forced game slot: starve_cnt==STARVE_LIMIT and FIFO non-empty.
  - (b) Renderer, when pixel_read=1.
  - (c) Game, when FIFO non-empty.
  - (d) Idle: ram_we=0, address holds its last value.
- Renderer read issued in cycle N gives mapa_valid=1 and mapa_cor=ram_rdata in N+1. Out-of-range reads issue no RAM access; they give mapa_cor=0 and mapa_valid=1 in N+1.
- A renderer read displaced by (a) gives mapa_miss=1 and mapa_valid=0 in N+1. mapa_cor holds its previous value.
- Game FIFO:
  - Each entry is {we, addr, wdata, oob}. Push on g_req&&g_ready.
  - g_ready = !full, computed from registered state. A push while full cannot occur.
  - Push and pop in the same cycle are allowed when not full.
- Game write: ram_we=1 for one cycle. Out-of-range writes are popped and dropped with no RAM access.
- Game read issued in N gives g_rvalid=1 and g_rdata=ram_rdata in N+1. Out-of-range reads give g_rdata=0 and g_rvalid=1 in N+1.
- Ordering: game operations complete strictly in FIFO order. A read after a write to the same address returns the new value.
- starve_cnt:
  - Increments each cycle the FIFO is non-empty and no game op is issued.
  - Clears to 0 on any game issue or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Reset, including mid-operation:
  - FIFO flushed; starve_cnt=0.
  - Outputs: mapa_cor=0, mapa_valid=0, mapa_miss=0, g_rvalid=0, g_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, g_ready=0 during reset, 1 the cycle after.
  - Any in-flight read result is discarded (no valid pulse after reset).
- Renderer and game read data never both valid in the same cycle.

Test Plan:
- Reset, then pixel_read=1 with x=3,y=2 and RAM word 83=6'h2A -> ram_addr=83 at N; mapa_valid=1, mapa_cor=6'h2A at N+1.
- pixel_read=0; game write (5,1)=6'h15, then game read (5,1) -> ram_we=1, addr=45 once; next cycle read issued; g_rvalid=1, g_rdata=6'h15 one cycle later.
- pixel_read held 1; push 5 requests -> g_ready=0 after 4 accepted. 5th request not accepted. No game op until cycle STARVE_LIMIT+1, then one game op with mapa_miss=1 the next cycle.
- Renderer x=40,y=0 -> no RAM access, mapa_cor=0, mapa_valid=1. Game write to y=30 -> dropped, RAM unchanged.
- Game read queued, reset asserted the cycle it issues -> no g_rvalid after reset, FIFO empty, g_ready=1 the cycle after reset deasserts.
- Interleave pixel_read toggling every cycle with 4 queued writes -> all 4 writes issued in pixel_read=0 cycles, in order. Every renderer read returns valid data at N+1.
